prg_loader: RTL and testbench
=============================

# prg_loader

Byte-stream program loader that sits directly upstream of the data memory's programmer port. It parses framed commands arriving one byte at a time from a host link (UART receiver or debug bridge), assembles big-endian 32-bit words, and drives `prg_we`/`prg_addr`/`prg_wd` to fill memory while `prg_mode` is high. It also reads memory back through `prg_rd` and returns bytes on an outgoing stream. `prg_clk` for the memory is this block's `clk`.

## Interface
- `ACK_BYTE`, 8'h06: byte emitted after a completed write command.
- `NAK_BYTE`, 8'h15: byte emitted on an unknown command byte.
- `clk`  in  1  single clock; also forwarded as memory `prg_clk`.
- `reset`  in  1  synchronous, active-high.
- `prg_mode`  in  1  1 = program mode; 0 forces the FSM to IDLE and drains input.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  byte consumed on a cycle where `rx_valid & rx_ready`.
- `tx_data`  out  8  outgoing byte.
- `tx_valid`  out  1  `tx_data` valid; held with stable data until accepted.
- `tx_ready`  in  1  downstream accepts on `tx_valid & tx_ready`.
- `prg_we`  out  1  one-cycle write strobe.
- `prg_addr`  out  32  byte address to memory.
- `prg_wd`  out  32  write data.
- `prg_rd`  in  32  read data from memory.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Frame: cmd byte, 4 addr bytes (MSB first), 2 count bytes N (MSB first). For cmd `0x57` ('W'), 4·N data bytes follow (each word MSB first). For cmd `0x52` ('R'), no data follows.
- States: IDLE, ADDR, CNT, WR_DATA, WR_STB, RD_WAIT, RD_SEND, RESP.
- IDLE: on a handshake with `0x57` or `0x52`, latch cmd and go to ADDR. On any other byte, load `NAK_BYTE` and go to RESP.
- ADDR: consume 4 bytes, shifting into `addr_q`, with a 2-bit byte counter. Then go to CNT.
- CNT: consume 2 bytes into `cnt_q`.
  - If N = 0: a 'W' goes to RESP (ACK); an 'R' goes to IDLE.
  - Otherwise: a 'W' goes to WR_DATA; an 'R' goes to RD_WAIT.
- WR_DATA: consume 4 bytes into `wd_q`, then go to WR_STB.
- WR_STB: `prg_we`=1 for exactly one cycle with `prg_addr`=`addr_q` and `prg_wd`=`wd_q`. Then `addr_q` += 4 (wraps modulo 2^32) and `cnt_q` -= 1. If the new count is 0, go to RESP (ACK); otherwise return to WR_DATA.
- RD_WAIT: drive `prg_addr`=`addr_q` for 2 cycles and capture `prg_rd` into `rd_q` at the end of the second cycle. This covers both asynchronous and single-cycle synchronous RAM reads. Then go to RD_SEND.
- RD_SEND: emit `rd_q[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, each held until `tx_ready`. After the 4th byte is accepted, `addr_q` += 4 and `cnt_q` -= 1. If the count is 0, go to IDLE; otherwise go to RD_WAIT.
- RESP: `tx_valid`=1 with the latched response byte; on accept, go to IDLE.
- `rx_ready`:
  - 1 in IDLE, ADDR, CNT and WR_DATA.
  - 0 in WR_STB, RD_WAIT, RD_SEND and RESP.
  - When `prg_mode`=0, `rx_ready`=1 and bytes are discarded.
- `prg_mode` falling mid-frame: the next cycle is IDLE, counters are cleared, a pending tx byte is dropped, and no `prg_we` is issued.
- `prg_mode` rising: begins in IDLE. There is no partial-frame recovery; the host must resend.
- `prg_addr` is not forced to word alignment. The low 2 bits pass through as received.

## Timing
- Reset (and `prg_mode`=0), next edge:
  - state IDLE;
  - `rx_ready` =1 (and =1 while `prg_mode`=0);
  - `tx_valid`, `tx_data`, `prg_we`, `busy` =0;
  - `prg_addr`, `prg_wd`, `addr_q`, `cnt_q` =0.
- All outputs are registered except `rx_ready`, which is decoded from state only (no combinational path from `rx_valid`).
- Write throughput: 5 cycles per word with back-to-back rx bytes (4 accepts + 1 strobe).
- The last data byte's handshake edge is followed by `prg_we` high in the next cycle.
- Read latency: first tx byte is valid 3 cycles after the final count-byte handshake (CNT→RD_WAIT, 2 wait cycles).
- Read throughput: 6 cycles per word at `tx_ready`=1.
- The `tx_valid`/`tx_data` hold rule applies under any `tx_ready` stall.

## Structure
- Shared package `prg_loader_pkg`: state enum, command constants `CMD_WRITE`=8'h57 and `CMD_READ`=8'h52, ACK/NAK defaults.
- One natural sub-module, `byte_shifter`: shifts 8-bit inputs into a 32-bit register with a 2-bit count and a `full` flag. It is reused for the addr, count and write-data assembly.
- The top-level integration ties memory `prg_clk` to `clk`.

## Test plan
- Reset mid-WR_DATA, then send 'W', 0x00000010, N=2, words 0xDEADBEEF and 0x12345678:
  - two `prg_we` pulses at addr 0x10 and 0x14 with those data;
  - `tx` emits 0x06;
  - `busy` drops after the accept.
- 'R', 0x00000010, N=2 against a RAM model: `tx` bytes are DE AD BE EF 12 34 56 78, with `tx_ready` toggling randomly and data stable while stalled.
- Byte 0x41: `tx` emits 0x15 and the FSM returns to IDLE. A following valid frame then executes normally.
- 'W' with N=0 gives ACK and no `prg_we`. 'R' with N=0 gives no tx bytes and returns to IDLE.
- Address wrap: 'W', 0xFFFFFFFC, N=2 writes at 0xFFFFFFFC then 0x00000000.
- Drop `prg_mode` after 2 of 4 data bytes: no `prg_we`, no tx, IDLE. Remaining bytes are swallowed with `rx_ready`=1.

Source files
------------

// File: rtl/prg_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Imported by the loader top and its byte shifter.
package prg_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_WR_DATA,
        S_WR_STB,
        S_RD_WAIT,
        S_RD_SEND,
        S_RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Byte i of a word, counted from the most significant end.
    function automatic logic [7:0] byte_sel(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        logic [7:0] b;
        unique case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/prg_loader_byte_shifter.sv
// Big-endian byte assembler: shifts bytes into a W-bit register.
// full pulses on the shift that completes the last byte of the word.
module byte_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         shift,
    input  logic [7:0]   din,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         full
);
    import prg_loader_pkg::*;

    localparam int NB = W / 8;
    localparam logic [1:0] LAST = 2'(NB - 1);

    logic [W-1:0] q_q, q_d;
    logic [1:0]   cnt_q, cnt_d;

    assign full = shift && (cnt_q == LAST);
    assign q    = q_q;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (load) begin
            q_d   = load_val;
            cnt_d = '0;
        end else if (shift) begin
            q_d   = {q_q[W-9:0], din};
            cnt_d = full ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prg_loader.sv
// Framed byte-stream loader driving the data memory programmer port.
// Parses W/R commands, writes words, and streams read data back.
module prg_loader
    import prg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        prg_mode,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prg_clk,
    output logic        prg_we,
    output logic [31:0] prg_addr,
    output logic [31:0] prg_wd,
    input  logic [31:0] prg_rd,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        wait_q, wait_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] rd_q, rd_d;
    logic        txv_q, txv_d;
    logic [7:0]  txd_q, txd_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;

    logic        clr;
    logic        a_shift, a_load, a_full;
    logic        c_shift, c_load, c_full;
    logic        w_shift, w_full;
    logic [31:0] a_q, w_q;
    logic [15:0] c_q, n_new;
    logic        acc, tx_acc;

    assign prg_clk  = clk;
    assign rx_ready = !prg_mode ||
                      (state_q inside {S_IDLE, S_ADDR, S_CNT, S_WR_DATA});
    assign acc      = rx_valid && rx_ready;
    assign tx_acc   = txv_q && tx_ready;
    assign n_new    = {c_q[7:0], rx_data};

    assign tx_valid = txv_q;
    assign tx_data  = txd_q;
    assign prg_we   = we_q;
    assign prg_addr = a_q;
    assign prg_wd   = w_q;
    assign busy     = busy_q;

    byte_shifter #(.W(32)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .shift    (a_shift),
        .din      (rx_data),
        .load     (a_load),
        .load_val (a_q + 32'd4),
        .q        (a_q),
        .full     (a_full)
    );

    byte_shifter #(.W(16)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .shift    (c_shift),
        .din      (rx_data),
        .load     (c_load),
        .load_val (c_q - 16'd1),
        .q        (c_q),
        .full     (c_full)
    );

    byte_shifter #(.W(32)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .shift    (w_shift),
        .din      (rx_data),
        .load     (1'b0),
        .load_val (32'd0),
        .q        (w_q),
        .full     (w_full)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
        we_d    = 1'b0;
        clr     = 1'b0;
        a_shift = 1'b0;
        a_load  = 1'b0;
        c_shift = 1'b0;
        c_load  = 1'b0;
        w_shift = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        cmd_d   = rx_data;
                        clr     = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        txv_d   = 1'b1;
                        txd_d   = NAK_BYTE;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (acc) begin
                    a_shift = 1'b1;
                    if (a_full) state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (acc) begin
                    c_shift = 1'b1;
                    if (c_full) begin
                        wait_d = 1'b0;
                        if (n_new == 16'd0) begin
                            if (cmd_q == CMD_WRITE) begin
                                txv_d   = 1'b1;
                                txd_d   = ACK_BYTE;
                                state_d = S_RESP;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else if (cmd_q == CMD_WRITE) begin
                            state_d = S_WR_DATA;
                        end else begin
                            state_d = S_RD_WAIT;
                        end
                    end
                end
            end
            S_WR_DATA: begin
                if (acc) begin
                    w_shift = 1'b1;
                    if (w_full) begin
                        we_d    = 1'b1;
                        state_d = S_WR_STB;
                    end
                end
            end
            S_WR_STB: begin
                a_load = 1'b1;
                c_load = 1'b1;
                if (c_q == 16'd1) begin
                    txv_d   = 1'b1;
                    txd_d   = ACK_BYTE;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_RD_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    // tx_data is registered, so the first byte comes from prg_rd
                    wait_d  = 1'b0;
                    rd_d    = prg_rd;
                    txv_d   = 1'b1;
                    txd_d   = prg_rd[31:24];
                    idx_d   = 2'd0;
                    state_d = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (tx_acc) begin
                    if (idx_q == 2'd3) begin
                        a_load  = 1'b1;
                        c_load  = 1'b1;
                        txv_d   = 1'b0;
                        state_d = (c_q == 16'd1) ? S_IDLE : S_RD_WAIT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        txd_d = byte_sel(rd_q, idx_q + 2'd1);
                    end
                end
            end
            S_RESP: begin
                if (tx_acc) begin
                    txv_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!prg_mode) begin
            state_d = S_IDLE;
            cmd_d   = '0;
            wait_d  = 1'b0;
            idx_d   = '0;
            txv_d   = 1'b0;
            txd_d   = '0;
            we_d    = 1'b0;
            clr     = 1'b1;
            a_shift = 1'b0;
            a_load  = 1'b0;
            c_shift = 1'b0;
            c_load  = 1'b0;
            w_shift = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            wait_q  <= 1'b0;
            idx_q   <= '0;
            rd_q    <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader with a frame-level expectation model.
module tb_prg_loader;
    import prg_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset, prg_mode, rx_valid, tx_ready;
    logic        rx_ready, tx_valid, prg_we, busy, prg_clk;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] prg_addr, prg_wd, prg_rd;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] ram [16];
    logic [31:0] mdl [logic [31:0]];
    logic [63:0] exp_we[$], we_log[$];
    logic [7:0]  exp_tx[$], tx_log[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always #5 clk = ~clk;

    prg_loader dut (
        .clk      (clk),
        .reset    (reset),
        .prg_mode (prg_mode),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .prg_clk  (prg_clk),
        .prg_we   (prg_we),
        .prg_addr (prg_addr),
        .prg_wd   (prg_wd),
        .prg_rd   (prg_rd),
        .busy     (busy)
    );

    assign prg_rd = ram[prg_addr[5:2]];
    always @(posedge prg_clk) if (prg_we) ram[prg_addr[5:2]] <= prg_wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prg_we) begin
                we_log.push_back({prg_addr, prg_wd});
                if (exp_we.size() == 0) begin
                    chk("unexpected_we", {prg_addr, prg_wd}, 64'hx);
                end else begin
                    logic [63:0] e;
                    e = exp_we.pop_front();
                    chk("we_addr", 64'(prg_addr), 64'(e[63:32]));
                    chk("we_data", 64'(prg_wd), 64'(e[31:0]));
                end
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    chk("unexpected_tx", 64'(tx_data), 64'hx);
                end else begin
                    chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                end
            end
            if (prev_stall && prg_mode) begin
                chk("tx_hold_valid", 64'(tx_valid), 64'd1);
                chk("tx_hold_data", 64'(tx_data), 64'(prev_data));
            end
            if (!prg_mode) chk("rx_ready_off", 64'(rx_ready), 64'd1);
        end
        prev_stall = tx_valid && !tx_ready && !reset && prg_mode;
        prev_data  = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("rx_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] n);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic do_write(input logic [31:0] a, input int n,
                            input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w, ad;
        for (int i = 0; i < n; i++) begin
            w  = (i == 0) ? w0 : w1;
            ad = a + 32'(4 * i);
            exp_we.push_back({ad, w});
            mdl[ad] = w;
        end
        exp_tx.push_back(ACK_BYTE);
        send_hdr(CMD_WRITE, a, 16'(n));
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
            @(negedge clk);
            chk("we_after_last_byte", 64'(prg_we), 64'd1);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input bit chk_lat);
        logic [31:0] w;
        int lat;
        for (int i = 0; i < n; i++) begin
            w = mdl[a + 32'(4 * i)];
            for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
        end
        send_hdr(CMD_READ, a, 16'(n));
        if (chk_lat) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!tx_valid && lat < 20);
            chk("read_latency", 64'(lat), 64'd3);
        end
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while ((exp_we.size() != 0 || exp_tx.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s: timeout, %0d we and %0d tx still expected",
                     nm, exp_we.size(), exp_tx.size());
        end
        checks++;
    endtask

    task automatic reset_state(input string nm);
        chk({nm, "_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({nm, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({nm, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({nm, "_prg_we"}, 64'(prg_we), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_prg_addr"}, 64'(prg_addr), 64'd0);
        chk({nm, "_prg_wd"}, 64'(prg_wd), 64'd0);
    endtask

    function automatic void clear_logs();
        we_log.delete();
        tx_log.delete();
    endfunction

    logic [7:0] lit_rd [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        reset    = 1'b1;
        prg_mode = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset_state("reset");

        send_hdr(CMD_WRITE, 32'h100, 16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset_state("midreset");

        clear_logs();
        do_write(32'h10, 2, 32'hDEADBEEF, 32'h12345678);
        wait_done("write2");
        chk("w2_count", 64'(we_log.size()), 64'd2);
        chk("w2_first", we_log[0], 64'h00000010_DEADBEEF);
        chk("w2_second", we_log[1], 64'h00000014_12345678);
        chk("w2_ack_count", 64'(tx_log.size()), 64'd1);
        chk("w2_ack", 64'(tx_log[0]), 64'h06);
        chk("w2_busy", 64'(busy), 64'd0);

        rand_rdy = 1'b1;
        clear_logs();
        do_read(32'h10, 2, 1'b1);
        wait_done("read2");
        chk("r2_count", 64'(tx_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("r2_byte", 64'(tx_log[i]), 64'(lit_rd[i]));

        clear_logs();
        exp_tx.push_back(NAK_BYTE);
        send_byte(8'h41);
        wait_done("nak");
        chk("nak_byte", 64'(tx_log[0]), 64'h15);
        chk("nak_idle", 64'(busy), 64'd0);
        clear_logs();
        do_write(32'h20, 1, 32'hCAFEF00D, 32'h0);
        wait_done("after_nak");
        chk("after_nak_we", we_log[0], 64'h00000020_CAFEF00D);

        clear_logs();
        do_write(32'h30, 0, 32'h0, 32'h0);
        wait_done("w0");
        chk("w0_no_we", 64'(we_log.size()), 64'd0);
        chk("w0_ack", 64'(tx_log[0]), 64'h06);
        clear_logs();
        do_read(32'h40, 0, 1'b0);
        wait_done("r0");
        repeat (5) @(negedge clk);
        chk("r0_no_tx", 64'(tx_log.size()), 64'd0);
        chk("r0_idle", 64'(busy), 64'd0);

        clear_logs();
        do_write(32'hFFFFFFFC, 2, 32'hA5A5A5A5, 32'h5A5A5A5A);
        wait_done("wrap");
        chk("wrap_first", we_log[0], 64'hFFFFFFFC_A5A5A5A5);
        chk("wrap_second", we_log[1], 64'h00000000_5A5A5A5A);
        do_read(32'hFFFFFFFC, 2, 1'b0);
        wait_done("wrap_read");

        rand_rdy = 1'b0;
        clear_logs();
        send_hdr(CMD_WRITE, 32'h50, 16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        prg_mode = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        @(negedge clk);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_addr", 64'(prg_addr), 64'd0);
        chk("drop_tx_valid", 64'(tx_valid), 64'd0);
        repeat (5) @(negedge clk);
        chk("drop_no_we", 64'(we_log.size()), 64'd0);
        chk("drop_no_tx", 64'(tx_log.size()), 64'd0);
        prg_mode = 1'b1;
        @(negedge clk);
        do_write(32'h50, 1, 32'h01020304, 32'h0);
        wait_done("after_drop");
        chk("after_drop_we", we_log[0], 64'h00000050_01020304);

        chk("exp_we_empty", 64'(exp_we.size()), 64'd0);
        chk("exp_tx_empty", 64'(exp_tx.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
